// File: rtl/alu_ex_buffer_if.sv
// Execute-to-memory handshake bundle for alu_ex_buffer.
// master: execute/memory side, slave: the buffer.
interface alu_ex_buffer_if #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_zero;
  logic [REGW-1:0]  in_rd;
  logic             in_regwrite;
  logic             in_memread;
  logic             in_memwrite;
  logic [WIDTH-1:0] in_store_data;
  logic [1:0]       in_branch_type;
  logic [WIDTH-1:0] in_branch_target;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [REGW-1:0]  out_rd;
  logic             out_regwrite;
  logic             out_memread;
  logic             out_memwrite;
  logic [WIDTH-1:0] out_store_data;
  logic             out_branch_taken;
  logic [WIDTH-1:0] out_branch_target;

  modport master (
    output in_valid, in_result, in_zero,
    output in_rd, in_regwrite,
    output in_memread, in_memwrite,
    output in_store_data,
    output in_branch_type,
    output in_branch_target,
    input  in_ready,
    input  out_valid, out_result, out_rd,
    input  out_regwrite,
    input  out_memread, out_memwrite,
    input  out_store_data,
    input  out_branch_taken,
    input  out_branch_target,
    output out_ready
  );

  modport slave (
    input  in_valid, in_result, in_zero,
    input  in_rd, in_regwrite,
    input  in_memread, in_memwrite,
    input  in_store_data,
    input  in_branch_type,
    input  in_branch_target,
    output in_ready,
    output out_valid, out_result, out_rd,
    output out_regwrite,
    output out_memread, out_memwrite,
    output out_store_data,
    output out_branch_taken,
    output out_branch_target,
    input  out_ready
  );
endinterface

// File: rtl/alu_ex_buffer.sv
// Two-entry skid buffer after the ALU: head drives the memory stage,
// skid absorbs one stall; resolves BEQ/BNE; counts retired results.
module alu_ex_buffer #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  alu_ex_buffer_if.slave bus,
  output logic [31:0] retire_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [REGW-1:0]  rd;
    logic             regwrite;
    logic             memread;
    logic             memwrite;
    logic [WIDTH-1:0] store_data;
    logic [1:0]       btype;
    logic [WIDTH-1:0] target;
  } entry_t;

  state_t state;
  entry_t head;
  entry_t skid;
  entry_t inp;
  logic   rdy_q;
  logic   vld_q;
  logic   accept;
  logic   drain;
  logic   beq_hit;
  logic   bne_hit;

  assign inp = '{
    result:     bus.in_result,
    zero:       bus.in_zero,
    rd:         bus.in_rd,
    regwrite:   bus.in_regwrite,
    memread:    bus.in_memread,
    memwrite:   bus.in_memwrite,
    store_data: bus.in_store_data,
    btype:      bus.in_branch_type,
    target:     bus.in_branch_target
  };

  assign accept = bus.in_valid & rdy_q;
  assign drain  = vld_q & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      rdy_q        <= 1'b1;
      vld_q        <= 1'b0;
      head         <= '0;
      skid         <= '0;
      retire_count <= '0;
    end else begin
      // a drain on the flush edge still completed downstream
      if (drain)
        retire_count <= retire_count + 32'd1;
      if (flush) begin
        state <= EMPTY;
        rdy_q <= 1'b1;
        vld_q <= 1'b0;
      end else begin
        unique case (state)
          EMPTY: begin
            if (accept) begin
              head  <= inp;
              state <= ONE;
              vld_q <= 1'b1;
            end
          end
          ONE: begin
            unique case ({accept, drain})
              2'b10: begin
                skid  <= inp;
                state <= FULL;
                rdy_q <= 1'b0;
              end
              2'b01: begin
                state <= EMPTY;
                vld_q <= 1'b0;
              end
              2'b11: head <= inp;
              default: ;
            endcase
          end
          FULL: begin
            // in_ready is low here, so no accept can race the move
            if (drain) begin
              head  <= skid;
              state <= ONE;
              rdy_q <= 1'b1;
            end
          end
          default: begin
            state <= EMPTY;
            rdy_q <= 1'b1;
            vld_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign beq_hit = (head.btype == 2'b01) & head.zero;
  assign bne_hit = (head.btype == 2'b10) & ~head.zero;

  assign bus.in_ready          = rdy_q;
  assign bus.out_valid         = vld_q;
  assign bus.out_result        = head.result;
  assign bus.out_rd            = head.rd;
  assign bus.out_regwrite      = head.regwrite;
  assign bus.out_memread       = head.memread;
  assign bus.out_memwrite      = head.memwrite;
  assign bus.out_store_data    = head.store_data;
  assign bus.out_branch_taken  = vld_q & (beq_hit | bne_hit);
  assign bus.out_branch_target = head.target;

endmodule

// File: tb/tb_alu_ex_buffer.sv
// Scoreboard bench for alu_ex_buffer: a capacity-2 FIFO model,
// directed scenarios plus a randomized phase.
module tb_alu_ex_buffer;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [31:0] sd;
    logic [1:0]  bt;
    logic [31:0] tgt;
  } pl_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] retire_count;

  alu_ex_buffer_if bus();

  alu_ex_buffer dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus(bus),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  pl_t         q[$];
  logic [31:0] exp_count = '0;
  int          checks = 0;
  int          passes = 0;
  bit          mon_en = 1'b0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h",
                  name, act, exp);
  endtask

  function automatic pl_t rnd_pl();
    pl_t p;
    p.result   = $urandom;
    p.zero     = 1'($urandom_range(0, 1));
    p.rd       = 5'($urandom_range(0, 31));
    p.regwrite = 1'($urandom_range(0, 1));
    p.memread  = 1'($urandom_range(0, 1));
    p.memwrite = 1'($urandom_range(0, 1));
    p.sd       = $urandom;
    p.bt       = 2'($urandom_range(0, 3));
    p.tgt      = $urandom;
    return p;
  endfunction

  function automatic pl_t mk(logic [31:0] r,
                             logic [1:0] bt, logic z,
                             logic [31:0] t);
    pl_t p;
    p = rnd_pl();
    p.result = r;
    p.bt     = bt;
    p.zero   = z;
    p.tgt    = t;
    return p;
  endfunction

  task automatic drive(pl_t p, logic v);
    bus.in_valid         = v;
    bus.in_result        = p.result;
    bus.in_zero          = p.zero;
    bus.in_rd            = p.rd;
    bus.in_regwrite      = p.regwrite;
    bus.in_memread       = p.memread;
    bus.in_memwrite      = p.memwrite;
    bus.in_store_data    = p.sd;
    bus.in_branch_type   = p.bt;
    bus.in_branch_target = p.tgt;
  endtask

  task automatic send(pl_t p, logic ordy);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(p, 1'b1);
      bus.out_ready = ordy;
      #2;
      if (bus.in_ready && !flush) begin
        q.push_back(p);
        return;
      end
    end
    chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(int n, logic ordy);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = ordy;
    end
  endtask

  // Monitor: compare head against model, then retire/flush the model.
  always @(negedge clk) begin
    pl_t h;
    logic taken;
    #1;
    if (rst_n && mon_en) begin
      chk("out_valid", bus.out_valid, q.size() > 0);
      chk("in_ready", bus.in_ready, q.size() < 2);
      chk("retire_count", retire_count, exp_count);
      if (q.size() > 0) begin
        h = q[0];
        taken = (h.bt == 2'b01 && h.zero) ||
                (h.bt == 2'b10 && !h.zero);
        chk("result", bus.out_result, h.result);
        chk("rd", bus.out_rd, h.rd);
        chk("regwrite", bus.out_regwrite, h.regwrite);
        chk("memread", bus.out_memread, h.memread);
        chk("memwrite", bus.out_memwrite, h.memwrite);
        chk("store_data", bus.out_store_data, h.sd);
        chk("target", bus.out_branch_target, h.tgt);
        chk("taken", bus.out_branch_taken, taken);
        if (bus.out_ready) begin
          void'(q.pop_front());
          exp_count = exp_count + 32'd1;
        end
      end else begin
        chk("taken_idle", bus.out_branch_taken, 1'b0);
      end
      if (flush) q.delete();
    end
  end

  initial begin
    pl_t p;
    logic v;
    logic [31:0] c0;
    bus.out_ready = 1'b0;
    drive(rnd_pl(), 1'b0);

    repeat (3) begin
      @(negedge clk);
      drive(rnd_pl(), 1'($urandom_range(0, 1)));
      bus.out_ready = 1'($urandom_range(0, 1));
      flush = 1'($urandom_range(0, 1));
      #1;
      chk("rst_valid", bus.out_valid, 1'b0);
      chk("rst_ready", bus.in_ready, 1'b1);
      chk("rst_count", retire_count, 32'd0);
      chk("rst_taken", bus.out_branch_taken, 1'b0);
      chk("rst_result", bus.out_result, 32'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush = 1'b0;
    #3 rst_n = 1'b1;
    mon_en = 1'b1;

    send(mk(32'h1, 2'b00, 1'b0, 32'h0), 1'b1);
    send(mk(32'h2, 2'b00, 1'b0, 32'h0), 1'b1);
    send(mk(32'h3, 2'b00, 1'b0, 32'h0), 1'b1);
    idle(3, 1'b1);
    #1 chk("stream_count", retire_count, 32'd3);

    send(mk(32'hA, 2'b00, 1'b0, 32'h0), 1'b0);
    send(mk(32'hB, 2'b00, 1'b0, 32'h0), 1'b0);
    p = mk(32'hC, 2'b00, 1'b0, 32'h0);
    repeat (3) begin
      @(negedge clk);
      drive(p, 1'b1);
      bus.out_ready = 1'b0;
      #2 chk("bp_held", bus.in_ready, 1'b0);
    end
    send(p, 1'b1);
    idle(4, 1'b1);
    #1 chk("bp_count", retire_count, 32'd6);

    send(mk(32'h10, 2'b01, 1'b1, 32'h40), 1'b1);
    send(mk(32'h11, 2'b10, 1'b1, 32'h44), 1'b1);
    send(mk(32'h12, 2'b10, 1'b0, 32'h48), 1'b1);
    send(mk(32'h13, 2'b11, 1'b1, 32'h4C), 1'b1);
    send(mk(32'h14, 2'b11, 1'b0, 32'h50), 1'b1);
    send(mk(32'h15, 2'b01, 1'b0, 32'h54), 1'b1);
    idle(2, 1'b1);

    send(mk(32'hE1, 2'b00, 1'b0, 32'h0), 1'b0);
    send(mk(32'hE2, 2'b00, 1'b0, 32'h0), 1'b0);
    c0 = exp_count;
    @(negedge clk);
    drive(mk(32'hD, 2'b00, 1'b0, 32'h0), 1'b1);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("flush_valid", bus.out_valid, 1'b0);
    chk("flush_ready", bus.in_ready, 1'b1);
    chk("flush_count", retire_count, c0 + 32'd1);
    idle(2, 1'b1);

    send(mk(32'hF0, 2'b00, 1'b0, 32'h0), 1'b0);
    idle(1, 1'b0);
    #3;
    force dut.retire_count = 32'hFFFF_FFFF;
    exp_count = 32'hFFFF_FFFF;
    #1 release dut.retire_count;
    idle(2, 1'b1);
    #1 chk("wrap", retire_count, 32'd0);

    send(mk(32'h77, 2'b01, 1'b1, 32'h0), 1'b0);
    send(mk(32'h78, 2'b01, 1'b1, 32'h0), 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_ready", bus.in_ready, 1'b1);
    chk("mid_rst_count", retire_count, 32'd0);
    chk("mid_rst_result", bus.out_result, 32'd0);
    chk("mid_rst_taken", bus.out_branch_taken, 1'b0);
    q.delete();
    exp_count = '0;
    @(negedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      p = rnd_pl();
      v = ($urandom_range(0, 3) != 0);
      drive(p, v);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      #2;
      if (v && bus.in_ready && !flush) q.push_back(p);
    end
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    idle(5, 1'b1);
    #1 chk("final_empty", bus.out_valid, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
